// File: rtl/multu_sequencer.sv
// Multi-cycle shift-add unsigned multiplier controller for the MULTU/MFHI/MFLO path.
// Optional MULTU_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module multu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_hi_req,
    input  logic             i_lo_req,
    input  logic             i_kill,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_finish;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_acc_sh;
    logic [WIDTH-1:0] w_mplier_sh;
    logic [2*WIDTH-1:0] w_result;

    // One shift-add step; acc[WIDTH] is always zero here because the previous shift cleared it.
    assign w_sum       = {1'b0, r_acc[WIDTH-1:0]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_sh    = {1'b0, w_sum[WIDTH:1]};
    assign w_mplier_sh = {w_sum[0], r_mplier[WIDTH-1:1]};

`ifdef MULTU_EARLY_EXIT_EN
    logic [CW:0]      w_steps;
    logic [CW:0]      w_align;
    logic [WIDTH-1:0] w_rem_mask;

    // After w_steps shifts, the unprocessed multiplier bits sit in the low WIDTH-w_steps bits.
    assign w_steps    = {1'b0, r_count} + (CW+1)'(1);
    assign w_align    = (CW+1)'(WIDTH) - w_steps;
    assign w_rem_mask = {WIDTH{1'b1}} >> w_steps;
    assign w_finish   = ((w_mplier_sh & w_rem_mask) == '0);
    assign w_result   = {w_acc_sh[WIDTH-1:0], w_mplier_sh} >> w_align;
`else
    assign w_finish   = (r_count == CW'(WIDTH-1));
    assign w_result   = {w_acc_sh[WIDTH-1:0], w_mplier_sh};
`endif

    assign w_accept = (r_state != S_RUN) && i_start && !i_kill;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = (r_state == S_RUN);
        o_done       = (r_state == S_DONE);
        o_stall      = o_busy && (i_hi_req || i_lo_req || i_start);
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (i_kill)        w_state_next = S_IDLE;
                else if (w_finish) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = w_accept ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_accept) begin
            r_acc    <= '0;
            r_mcand  <= i_op_a;
            r_mplier <= i_op_b;
            r_count  <= '0;
        end else if (r_state == S_RUN && !i_kill) begin
            r_acc    <= w_acc_sh;
            r_mplier <= w_mplier_sh;
            r_count  <= r_count + CW'(1);
            // HI/LO only move on a completing edge that was not flushed.
            if (w_finish) begin
                r_hi <= w_result[2*WIDTH-1:WIDTH];
                r_lo <= w_result[WIDTH-1:0];
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: tb/tb_multu_sequencer.sv
// Self-checking bench for multu_sequencer: scoreboard of expected {hi,lo} products.
module tb_multu_sequencer;
    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic         hi_req = 1'b0;
    logic         lo_req = 1'b0;
    logic         kill   = 1'b0;
    logic [W-1:0] op_a   = '0;
    logic [W-1:0] op_b   = '0;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_vec = 0;
    int n_err = 0;
    logic [2*W-1:0] sb[$];

    always #5 clk = ~clk;

    multu_sequencer #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .i_hi_req (hi_req),
        .i_lo_req (lo_req),
        .i_kill   (kill),
        .o_stall  (stall),
        .o_busy   (busy),
        .o_done   (done),
        .o_hi     (hi),
        .o_lo     (lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_len(input logic [W-1:0] b);
`ifdef MULTU_EARLY_EXIT_EN
        int m = 0;
        for (int i = 0; i < W; i++) if (b[i]) m = i + 1;
        return (m == 0) ? 1 : m;
`else
        return W;
`endif
    endfunction

    // Presents start for exactly one edge (E0); returns just after E0.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        logic [2*W-1:0] wa;
        logic [2*W-1:0] wb;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        op_a = a;
        op_b = b;
        if (push) sb.push_back(wa * wb);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges after E0 until done is seen; lat stays -1 on timeout.
    task automatic collect(output int lat, output logic [2*W-1:0] res);
        lat = -1;
        res = 'x;
        for (int k = 1; k <= W + 8; k++) begin
            tick();
            if (done) begin
                lat = k;
                res = {hi, lo};
                break;
            end
        end
        $display("txn a=%h b=%h -> hi=%h lo=%h latency=%0d", op_a, op_b, res[2*W-1:W], res[W-1:0], lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_vec++; if (hi !== '0)    begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_vec++; if (lo !== '0)    begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_vec++; if (done !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [2*W-1:0] res;
        logic [2*W-1:0] exp;
        launch(32'd7, 32'd9, 1'b0);
        repeat (9) tick();
        hi_req = 1'b1;
        rst_n  = 1'b0;
        #1;
        n_vec++; if (hi !== '0)      begin n_err++; $display("FAIL rstrun_hi: got %h want 0", hi); end
        n_vec++; if (lo !== '0)      begin n_err++; $display("FAIL rstrun_lo: got %h want 0", lo); end
        n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rstrun_busy: got %b want 0", busy); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rstrun_stall: got %b want 0", stall); end
        n_vec++; if (done !== 1'b0)  begin n_err++; $display("FAIL rstrun_done: got %b want 0", done); end
        hi_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        launch(32'd3, 32'd5, 1'b1);
        collect(lat, res);
        exp = sb.pop_front();
        n_vec++; if (lat !== exp_len(32'd5)) begin n_err++; $display("FAIL rstrun_lat: got %0d want %0d", lat, exp_len(32'd5)); end
        n_vec++; if (res !== exp) begin n_err++; $display("FAIL rstrun_prod: got %h want %h", res, exp); end
        n_vec++; if (lo !== 32'd15 || hi !== 32'd0) begin n_err++; $display("FAIL rstrun_15: got %h_%h want 0_f", hi, lo); end
    endtask

    task automatic test_full_width();
        int lat;
        logic [2*W-1:0] res;
        logic [2*W-1:0] exp;
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        collect(lat, res);
        exp = sb.pop_front();
        n_vec++; if (lat !== W) begin n_err++; $display("FAIL full_lat: got %0d want %0d", lat, W); end
        n_vec++; if (res !== exp) begin n_err++; $display("FAIL full_prod: got %h want %h", res, exp); end
        n_vec++; if (res !== 64'hFFFF_FFFE_0000_0001) begin n_err++; $display("FAIL full_const: got %h want fffffffe00000001", res); end
        tick();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL full_done_width: got %b want 0", done); end
    endtask

    task automatic test_hazard_stall();
        int lat = -1;
        int stall_cycles = 0;
        int n;
        logic [2*W-1:0] exp;
        n = exp_len(32'h10);
        launch(32'h1234_5678, 32'h0000_0010, 1'b1);
        hi_req = 1'b1;
        for (int k = 1; k <= W + 8; k++) begin
            if (k == 3) begin
                hi_req = 1'b0;
                start  = 1'b1;
                #1;
                n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL start_in_run_stall: got %b want 1", stall); end
            end else begin
                #1;
            end
            if (stall) stall_cycles++;
            tick();
            if (k == 3) begin
                start  = 1'b0;
                hi_req = 1'b1;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        $display("txn a=%h b=%h -> hi=%h lo=%h latency=%0d", op_a, op_b, hi, lo, lat);
        exp = sb.pop_front();
        n_vec++; if (lat !== n) begin n_err++; $display("FAIL hazard_lat: got %0d want %0d", lat, n); end
        n_vec++; if (stall_cycles !== n) begin n_err++; $display("FAIL hazard_stall_cycles: got %0d want %0d", stall_cycles, n); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL hazard_done_stall: got %b want 0", stall); end
        n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL hazard_prod: got %h_%h want %h", hi, lo, exp); end
        n_vec++; if (hi !== 32'h1 || lo !== 32'h2345_6780) begin n_err++; $display("FAIL hazard_const: got %h_%h want 00000001_23456780", hi, lo); end
        hi_req = 1'b0;
        tick();
    endtask

    task automatic test_kill();
        int lat;
        int done_seen = 0;
        int ke;
        int n;
        logic [2*W-1:0] res;
        logic [2*W-1:0] exp;
        launch(32'hFFFF_FFFF, 32'hAAAA_AAAB, 1'b1);
        collect(lat, res);
        exp = sb.pop_front();
        n_vec++; if (res !== exp) begin n_err++; $display("FAIL kill_prior_prod: got %h want %h", res, exp); end
        n_vec++; if (res !== 64'hAAAA_AAAA_5555_5555) begin n_err++; $display("FAIL kill_prior_const: got %h want aaaaaaaa55555555", res); end
        tick();
`ifdef MULTU_EARLY_EXIT_EN
        ke = 1;
`else
        ke = 5;
`endif
        launch(32'd2, 32'd3, 1'b0);
        repeat (ke - 1) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL kill_idle: busy got %b want 0", busy); end
        for (int k = 0; k < W + 4; k++) begin
            if (done) done_seen++;
            tick();
        end
        n_vec++; if (done_seen !== 0) begin n_err++; $display("FAIL kill_no_done: got %0d pulses want 0", done_seen); end
        n_vec++; if ({hi, lo} !== 64'hAAAA_AAAA_5555_5555) begin n_err++; $display("FAIL kill_hold: got %h_%h want aaaaaaaa_55555555", hi, lo); end
        // Flush landing on the completion edge.
        n = exp_len(32'd3);
        launch(32'd2, 32'd3, 1'b0);
        repeat (n - 1) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL kill_last_state: got done=%b busy=%b want 0 0", done, busy); end
        n_vec++; if ({hi, lo} !== 64'hAAAA_AAAA_5555_5555) begin n_err++; $display("FAIL kill_last_hold: got %h_%h want aaaaaaaa_55555555", hi, lo); end
        // Flush masks start in IDLE.
        start = 1'b1;
        kill  = 1'b1;
        tick();
        start = 1'b0;
        kill  = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL kill_masks_start: busy got %b want 0", busy); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [2*W-1:0] res;
        logic [2*W-1:0] exp;
        launch(32'd3, 32'd5, 1'b1);
        collect(lat, res);
        exp = sb.pop_front();
        n_vec++; if (lat !== exp_len(32'd5)) begin n_err++; $display("FAIL b2b_lat1: got %0d want %0d", lat, exp_len(32'd5)); end
        n_vec++; if (res !== exp || lo !== 32'd15) begin n_err++; $display("FAIL b2b_prod1: got %h want %h", res, exp); end
        launch(32'd4, 32'd4, 1'b1);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_no_gap: busy got %b want 1", busy); end
        n_vec++; if (lo !== 32'd15) begin n_err++; $display("FAIL b2b_lo_kept: got %h want f", lo); end
        collect(lat, res);
        exp = sb.pop_front();
        n_vec++; if (lat !== exp_len(32'd4)) begin n_err++; $display("FAIL b2b_lat2: got %0d want %0d", lat, exp_len(32'd4)); end
        n_vec++; if (res !== exp || lo !== 32'd16) begin n_err++; $display("FAIL b2b_prod2: got %h want %h", res, exp); end
        tick();
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_full_width();
        test_hazard_stall();
        test_kill();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
